// File: rtl/mem_access.sv
// MEM-stage load/store engine: serialises byte/half/word accesses onto an 8-bit RAM port
// and holds the pipeline until the write-back result is ready.
module mem_access #(
   parameter int unsigned MEM_ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [1:0]            mem_size_i,
   input  logic                  mem_sext_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           wdata_i,
   input  logic [4:0]            rd_i,
   input  logic                  wreg_i,
   input  logic [7:0]            mem_din_i,
   output logic [MEM_ADDR_W-1:0] mem_a_o,
   output logic [7:0]            mem_dout_o,
   output logic                  mem_wr_o,
   output logic [4:0]            rd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic                  stall_req_o
);

   typedef enum logic [1:0] {StIdle, StXfer, StLastRd, StDone} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [MEM_ADDR_W-1:0] r_addr;
   logic [31:0]           r_data;
   logic [1:0]            r_size;
   logic                  r_sext;
   logic [4:0]            r_rd;
   logic                  r_wreg;
   logic                  r_we;
   logic [1:0]            r_k;
   logic [31:0]           r_result;

   logic [1:0]            w_last_k;
   logic [7:0]            w_byte;
   logic [31:0]           w_ext;
   logic [1:0]            w_prev_k;

   assign w_prev_k = r_k - 2'd1;

   always_comb begin
      unique case (r_size)
         2'b00:   w_last_k = 2'd0;
         2'b01:   w_last_k = 2'd1;
         default: w_last_k = 2'd3;
      endcase
   end

   always_comb begin
      unique case (r_k)
         2'd0:    w_byte = r_data[7:0];
         2'd1:    w_byte = r_data[15:8];
         2'd2:    w_byte = r_data[23:16];
         default: w_byte = r_data[31:24];
      endcase
   end

   always_comb begin
      unique case (r_size)
         2'b00:   w_ext = {{24{r_sext & r_result[7]}}, r_result[7:0]};
         2'b01:   w_ext = {{16{r_sext & r_result[15]}}, r_result[15:0]};
         default: w_ext = r_result;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      stall_req_o  = 1'b0;
      rd_o         = 5'd0;
      wreg_o       = 1'b0;
      wdata_o      = 32'd0;
      mem_a_o      = '0;
      mem_dout_o   = 8'd0;
      mem_wr_o     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (mem_req_i) begin
               stall_req_o  = 1'b1;
               w_state_next = StXfer;
            end else begin
               rd_o    = rd_i;
               wreg_o  = wreg_i;
               wdata_o = wdata_i;
            end
         end
         StXfer: begin
            stall_req_o = 1'b1;
            // Address arithmetic wraps naturally at the port width.
            mem_a_o     = r_addr + MEM_ADDR_W'(r_k);
            mem_wr_o    = r_we;
            mem_dout_o  = w_byte;
            if (r_k == w_last_k) begin
               w_state_next = r_we ? StDone : StLastRd;
            end
         end
         StLastRd: begin
            stall_req_o  = 1'b1;
            w_state_next = StDone;
         end
         StDone: begin
            rd_o = r_rd;
            if (!r_we) begin
               wreg_o  = r_wreg;
               wdata_o = w_ext;
            end
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_addr   <= '0;
         r_data   <= 32'd0;
         r_size   <= 2'd0;
         r_sext   <= 1'b0;
         r_rd     <= 5'd0;
         r_wreg   <= 1'b0;
         r_we     <= 1'b0;
         r_k      <= 2'd0;
         r_result <= 32'd0;
      end else begin
         r_state <= w_state_next;
         unique case (r_state)
            StIdle: begin
               if (mem_req_i) begin
                  r_addr   <= mem_addr_i[MEM_ADDR_W-1:0];
                  r_data   <= wdata_i;
                  r_size   <= mem_size_i;
                  r_sext   <= mem_sext_i;
                  r_rd     <= rd_i;
                  r_wreg   <= wreg_i;
                  r_we     <= mem_we_i;
                  r_k      <= 2'd0;
                  r_result <= 32'd0;
               end
            end
            StXfer: begin
               // RAM returns data one cycle late, so this cycle's byte belongs to index k-1.
               if (!r_we && (r_k != 2'd0)) begin
                  r_result[{w_prev_k, 3'b000} +: 8] <= mem_din_i;
               end
               if (r_k != w_last_k) begin
                  r_k <= r_k + 2'd1;
               end
            end
            StLastRd: r_result[{r_k, 3'b000} +: 8] <= mem_din_i;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of load/store vectors through a scoreboard,
// plus hand sequences for pass-through, back-to-back issue and mid-access reset.
module tb_mem_access;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wreg;
      logic [31:0] exp_wdata;
      int          exp_stall;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic        wreg;
      logic [31:0] wdata;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [1:0]  mem_size_i;
   logic        mem_sext_i;
   logic [31:0] mem_addr_i;
   logic [31:0] wdata_i;
   logic [4:0]  rd_i;
   logic        wreg_i;
   logic [7:0]  mem_din_i;
   logic [31:0] mem_a_o;
   logic [7:0]  mem_dout_o;
   logic        mem_wr_o;
   logic [4:0]  rd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stall_req_o;

   logic [7:0]  ram [0:1023];
   logic [31:0] wr_a_q [$];
   logic [7:0]  wr_d_q [$];
   wb_t         exp_q [$];
   vec_t        vecs [13];
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   mem_access #(.MEM_ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req_i   (mem_req_i),
      .mem_we_i    (mem_we_i),
      .mem_size_i  (mem_size_i),
      .mem_sext_i  (mem_sext_i),
      .mem_addr_i  (mem_addr_i),
      .wdata_i     (wdata_i),
      .rd_i        (rd_i),
      .wreg_i      (wreg_i),
      .mem_din_i   (mem_din_i),
      .mem_a_o     (mem_a_o),
      .mem_dout_o  (mem_dout_o),
      .mem_wr_o    (mem_wr_o),
      .rd_o        (rd_o),
      .wreg_o      (wreg_o),
      .wdata_o     (wdata_o),
      .stall_req_o (stall_req_o)
   );

   // Byte RAM with one-cycle read latency, indexed by the low 10 address bits; preset in reset.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
         ram[10'h003] <= 8'h80;
         ram[10'h010] <= 8'h01;
         ram[10'h011] <= 8'h80;
         ram[10'h020] <= 8'h11;
         ram[10'h022] <= 8'h33;
         ram[10'h023] <= 8'h44;
         ram[10'h200] <= 8'h78;
         ram[10'h201] <= 8'h56;
         ram[10'h202] <= 8'h34;
         ram[10'h203] <= 8'h12;
         ram[10'h204] <= 8'h9A;
         mem_din_i    <= 8'h00;
      end else begin
         if (mem_wr_o) ram[mem_a_o[9:0]] <= mem_dout_o;
         mem_din_i <= ram[mem_a_o[9:0]];
      end
   end

   always @(negedge clk) begin
      if (!rst && mem_wr_o) begin
         wr_a_q.push_back(mem_a_o);
         wr_d_q.push_back(mem_dout_o);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic req, input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input logic wreg);
      mem_req_i  = req;
      mem_we_i   = we;
      mem_size_i = size;
      mem_sext_i = sext;
      mem_addr_i = addr;
      wdata_i    = data;
      rd_i       = rd;
      wreg_i     = wreg;
   endtask

   // Issues one request, holds it through DONE, then returns just after the next rising edge.
   task automatic run_vec(input vec_t v, input string tag);
      wb_t         e;
      int          stalls;
      bit          done;
      int          n;
      logic [31:0] exp_a;
      n = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
      wr_a_q.delete();
      wr_d_q.delete();
      drive(1'b1, v.we, v.size, v.sext, v.addr, v.data, v.rd, v.wreg);
      e.rd    = v.rd;
      e.wreg  = v.we ? 1'b0 : v.wreg;
      e.wdata = v.exp_wdata;
      exp_q.push_back(e);
      @(negedge clk);
      chk({tag, " req-cycle stall"}, 32'(stall_req_o), 32'd1);
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (stall_req_o) stalls++;
         else done = 1'b1;
      end
      if (done) begin
         e = exp_q.pop_front();
         chk({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
         chk({tag, " rd_o"}, 32'(rd_o), 32'(e.rd));
         chk({tag, " wreg_o"}, 32'(wreg_o), 32'(e.wreg));
         chk({tag, " wdata_o"}, wdata_o, e.wdata);
      end else begin
         total++;
         $display("FAIL %s timeout: stall_req_o still %0b after 12 cycles, expected 0", tag,
                  stall_req_o);
         exp_q.delete();
      end
      chk({tag, " write count"}, 32'(wr_a_q.size()), v.we ? 32'(n) : 32'd0);
      if (v.we) begin
         for (int k = 0; k < n && k < wr_a_q.size(); k++) begin
            exp_a = v.addr + 32'(k);
            chk($sformatf("%s write%0d addr", tag, k), wr_a_q[k], exp_a);
            chk($sformatf("%s write%0d data", tag, k), 32'(wr_d_q[k]), 32'(v.data[8*k +: 8]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic abort_mid(input vec_t v, input string tag);
      logic [31:0] exp_a;
      exp_a = v.addr + 32'd1;
      drive(1'b1, v.we, v.size, v.sext, v.addr, v.data, v.rd, v.wreg);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk({tag, " stall before reset"}, 32'(stall_req_o), 32'd1);
      chk({tag, " addr before reset"}, mem_a_o, exp_a);
      chk({tag, " wr before reset"}, 32'(mem_wr_o), 32'(v.we));
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      rst = 1'b1;
      #1;
      chk({tag, " wr after reset"}, 32'(mem_wr_o), 32'd0);
      chk({tag, " stall after reset"}, 32'(stall_req_o), 32'd0);
      chk({tag, " addr after reset"}, mem_a_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{we:1, size:2, sext:0, addr:32'h100, data:32'hDEADBEEF, rd:3, wreg:1,
                   exp_wdata:32'h0, exp_stall:4};
      vecs[1]  = '{we:0, size:2, sext:0, addr:32'h200, data:32'h0, rd:9, wreg:1,
                   exp_wdata:32'h12345678, exp_stall:5};
      vecs[2]  = '{we:0, size:0, sext:1, addr:32'h3, data:32'h0, rd:1, wreg:1,
                   exp_wdata:32'hFFFFFF80, exp_stall:2};
      vecs[3]  = '{we:0, size:0, sext:0, addr:32'h3, data:32'h0, rd:2, wreg:1,
                   exp_wdata:32'h00000080, exp_stall:2};
      vecs[4]  = '{we:0, size:1, sext:1, addr:32'h10, data:32'h0, rd:10, wreg:1,
                   exp_wdata:32'hFFFF8001, exp_stall:3};
      vecs[5]  = '{we:0, size:1, sext:0, addr:32'h10, data:32'h0, rd:11, wreg:0,
                   exp_wdata:32'h00008001, exp_stall:3};
      vecs[6]  = '{we:1, size:1, sext:0, addr:32'hFFFFFFFF, data:32'h1234ABCD, rd:12, wreg:1,
                   exp_wdata:32'h0, exp_stall:2};
      vecs[7]  = '{we:0, size:1, sext:0, addr:32'hFFFFFFFF, data:32'h0, rd:13, wreg:1,
                   exp_wdata:32'h0000ABCD, exp_stall:3};
      vecs[8]  = '{we:1, size:0, sext:0, addr:32'h21, data:32'h0000005A, rd:14, wreg:1,
                   exp_wdata:32'h0, exp_stall:1};
      vecs[9]  = '{we:0, size:3, sext:0, addr:32'h20, data:32'h0, rd:15, wreg:1,
                   exp_wdata:32'h44335A11, exp_stall:5};
      vecs[10] = '{we:0, size:2, sext:0, addr:32'h201, data:32'h0, rd:16, wreg:1,
                   exp_wdata:32'h9A123456, exp_stall:5};
      vecs[11] = '{we:0, size:1, sext:1, addr:32'h200, data:32'h0, rd:17, wreg:1,
                   exp_wdata:32'h00005678, exp_stall:3};
      vecs[12] = '{we:0, size:2, sext:0, addr:32'h100, data:32'h0, rd:0, wreg:1,
                   exp_wdata:32'hDEADBEEF, exp_stall:5};

      rst = 1'b1;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset mem_a_o", mem_a_o, 32'd0);
      chk("reset mem_wr_o", 32'(mem_wr_o), 32'd0);
      chk("reset mem_dout_o", 32'(mem_dout_o), 32'd0);
      chk("reset stall", 32'(stall_req_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'h55, 5'd7, 1'b1);
      #1;
      chk("alu rd_o", 32'(rd_o), 32'd7);
      chk("alu wreg_o", 32'(wreg_o), 32'd1);
      chk("alu wdata_o", wdata_o, 32'h55);
      chk("alu stall", 32'(stall_req_o), 32'd0);
      chk("alu mem_wr_o", 32'(mem_wr_o), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back: LW completes, the following ALU op must appear the very next cycle.
      run_vec(vecs[1], "b2b lw");
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'h77, 5'd4, 1'b1);
      #1;
      chk("b2b alu rd_o", 32'(rd_o), 32'd4);
      chk("b2b alu wreg_o", 32'(wreg_o), 32'd1);
      chk("b2b alu wdata_o", wdata_o, 32'h77);
      chk("b2b alu stall", 32'(stall_req_o), 32'd0);
      @(posedge clk);
      #1;

      abort_mid(vecs[1], "abort lw");
      run_vec(vecs[1], "after abort lw");
      abort_mid(vecs[0], "abort sw");
      run_vec(vecs[4], "after abort sw");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
